// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level open-drain I2C master engine.
// Executes one START / STOP / WRITE / READ command at a time and drives SCL/SDA
// as open-drain enables. Each bit is four quarter-bit phases q0..q3. A slave
// may stretch SCL; the engine waits in q2 until SCL is really high.
// Ports:
//   clk, reset        system clock, async active-low reset
//   cmd_valid/ready   command handshake (ready = ~busy)
//   cmd               00 START, 01 STOP, 10 WRITE, 11 READ
//   tx_byte           WRITE data (MSB first), captured at acceptance
//   nack_on_read      READ: 1 = NACK in 9th bit, captured at acceptance
//   rx_byte           READ result
//   ack_received      WRITE: sampled 9th bit; 1 after an illegal command
//   rsp_valid         one-cycle pulse when an accepted command completes
//   busy, bus_active  engine busy / bus owned (START done, no STOP yet)
//   scl_oe, sda_oe    1 = pull line low, 0 = release
//   scl_in, sda_in    sensed line levels
module i2c_byte_master #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_byte,
  input  logic       nack_on_read,
  output logic [7:0] rx_byte,
  output logic       ack_received,
  output logic       rsp_valid,
  output logic       busy,
  output logic       bus_active,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_DATA, S_ACK} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    q_q, q_d;
  logic [2:0]    bit_q, bit_d;
  logic          rd_q, rd_d;
  logic [7:0]    tx_q, tx_d;
  logic          nack_q, nack_d;
  logic [7:0]    rx_q, rx_d;
  logic          ack_q, ack_d;
  logic          rsp_q, rsp_d;
  logic          done_q, done_d;
  logic          bus_q, bus_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;

  logic tick, stall, enter, busy_w;

  // done_q marks the cycle after the last quarter; the response pulse follows
  // it, and busy covers both so nothing is accepted before rsp_valid.
  assign busy_w       = (state_q != S_IDLE) | done_q;
  assign busy         = busy_w;
  assign cmd_ready    = ~busy_w;
  assign rsp_valid    = rsp_q;
  assign rx_byte      = rx_q;
  assign ack_received = ack_q;
  assign bus_active   = bus_q;
  assign scl_oe       = scl_q;
  assign sda_oe       = sda_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      q_q     <= 2'd0;
      bit_q   <= 3'd7;
      rd_q    <= 1'b0;
      tx_q    <= 8'h00;
      nack_q  <= 1'b0;
      rx_q    <= 8'h00;
      ack_q   <= 1'b0;
      rsp_q   <= 1'b0;
      done_q  <= 1'b0;
      bus_q   <= 1'b0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      q_q     <= q_d;
      bit_q   <= bit_d;
      rd_q    <= rd_d;
      tx_q    <= tx_d;
      nack_q  <= nack_d;
      rx_q    <= rx_d;
      ack_q   <= ack_d;
      rsp_q   <= rsp_d;
      done_q  <= done_d;
      bus_q   <= bus_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    q_d     = q_q;
    bit_d   = bit_q;
    rd_d    = rd_q;
    tx_d    = tx_q;
    nack_d  = nack_q;
    rx_d    = rx_q;
    ack_d   = ack_q;
    rsp_d   = done_q;
    done_d  = 1'b0;
    bus_d   = bus_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    enter   = 1'b0;

    tick  = (div_q == DW'(CLK_DIV - 1));
    // SCL released by us but still low in q2: a slave is stretching.
    stall = (q_q == 2'd2) && !scl_q && !scl_in;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && !busy_w) begin
          div_d  = '0;
          q_d    = 2'd0;
          bit_d  = 3'd7;
          rd_d   = (cmd == CMD_READ);
          tx_d   = tx_byte;
          nack_d = nack_on_read;
          if (cmd == CMD_START) begin
            state_d = S_START;
            enter   = 1'b1;
          end else if (!bus_q) begin
            // no bus owned: reject without touching the lines
            done_d = 1'b1;
            ack_d  = 1'b1;
          end else if (cmd == CMD_STOP) begin
            state_d = S_STOP;
            enter   = 1'b1;
          end else begin
            state_d = S_DATA;
            enter   = 1'b1;
          end
        end
      end
      default: begin
        if (!stall) begin
          if (!tick) begin
            div_d = div_q + 1'b1;
          end else begin
            div_d = '0;
            q_d   = q_q + 2'd1;
            // sample at the end of the SCL-high quarter
            if (q_q == 2'd2) begin
              if (state_q == S_DATA && rd_q) rx_d = {rx_q[6:0], sda_in};
              if (state_q == S_ACK && !rd_q) ack_d = sda_in;
            end
            if (q_q == 2'd3) begin
              case (state_q)
                S_START: begin
                  bus_d   = 1'b1;
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end
                S_STOP: begin
                  bus_d   = 1'b0;
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end
                S_DATA: begin
                  if (bit_q == 3'd0) state_d = S_ACK;
                  else               bit_d   = bit_q - 3'd1;
                end
                default: begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end
              endcase
            end
            enter = (state_d != S_IDLE);
          end
        end
      end
    endcase

    // Line actions are applied on entry to each quarter and then held.
    if (enter) begin
      case (state_d)
        S_START: begin
          case (q_d)
            2'd0:    sda_d = 1'b0;
            2'd1:    scl_d = 1'b0;
            2'd2:    sda_d = 1'b1;
            default: scl_d = 1'b1;
          endcase
        end
        S_STOP: begin
          case (q_d)
            2'd0: begin
              scl_d = 1'b1;
              sda_d = 1'b1;
            end
            2'd1:    scl_d = 1'b0;
            2'd2:    sda_d = 1'b0;
            default: ;
          endcase
        end
        default: begin
          case (q_d)
            2'd0: begin
              scl_d = 1'b1;
              if (state_d == S_DATA) sda_d = rd_d ? 1'b0 : ~tx_d[bit_d];
              else                   sda_d = rd_d ? ~nack_d : 1'b0;
            end
            2'd1:    scl_d = 1'b0;
            2'd3:    scl_d = 1'b1;
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: open-drain bus with a behavioural slave that
// ACKs writes, returns read data, and can stretch SCL; randomized commands are
// checked against a transaction-level model of latency, bus bits and results.
module tb_i2c_byte_master;
  localparam int CLK_DIV = 4;
  localparam int QLAT = 4 * CLK_DIV + 1;
  localparam int BLAT = 36 * CLK_DIV + 1;
  localparam int STRETCH = 20;

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready, nack_on_read;
  logic [1:0] cmd;
  logic [7:0] tx_byte, rx_byte;
  logic ack_received, rsp_valid, busy, bus_active;
  logic scl_oe, sda_oe, scl_in, sda_in;

  always #5 clk = ~clk;

  i2c_byte_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .tx_byte(tx_byte), .nack_on_read(nack_on_read),
    .rx_byte(rx_byte), .ack_received(ack_received), .rsp_valid(rsp_valid),
    .busy(busy), .bus_active(bus_active), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_in(scl_in), .sda_in(sda_in)
  );

  // ---------------- slave / bus monitor ----------------
  int cmd_id = 0, seen_id = 0;
  int nfall = 0, rel_cnt = 0, stretch_cnt = 0, start_cnt = 0, stop_cnt = 0;
  int seen_n = 0;
  logic [8:0] seen_bits = '0;
  logic stretch = 1'b0;
  bit stretch_arm = 0;
  int slv_mode = 0;            // 0 idle, 1 write target, 2 read source
  logic [7:0] slv_byte = 8'h00;
  bit slv_ack = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1, prev_scl_oe = 1'b0;

  function automatic logic slave_drive(int m, int nf, logic [7:0] b, bit a);
    if (m == 2 && nf < 8) return ~b[3'(7 - nf)];
    if (m == 1 && nf == 8) return a;
    return 1'b0;
  endfunction

  assign scl_in = ~scl_oe & ~stretch;
  assign sda_in = ~sda_oe & ~slave_drive(slv_mode, nfall, slv_byte, slv_ack);

  always @(negedge clk) begin
    logic scl_now, sda_now;
    if (seen_id != cmd_id) begin
      seen_id   = cmd_id;
      nfall     = 0;
      rel_cnt   = 0;
      seen_n    = 0;
      seen_bits = '0;
    end
    if (stretch_cnt > 0) begin
      stretch_cnt--;
      if (stretch_cnt == 0) stretch = 1'b0;
    end
    // hold SCL from the 5th release (bit 3) through q1, then STRETCH cycles of q2
    if (prev_scl_oe && !scl_oe) begin
      rel_cnt++;
      if (stretch_arm && rel_cnt == 5) begin
        stretch     = 1'b1;
        stretch_cnt = CLK_DIV + STRETCH;
      end
    end
    scl_now = ~scl_oe & ~stretch;
    sda_now = ~sda_oe & ~slave_drive(slv_mode, nfall, slv_byte, slv_ack);
    if (!prev_scl && scl_now) begin
      if (seen_n < 9) seen_bits = {seen_bits[7:0], sda_now};
      seen_n++;
    end
    if (prev_scl && !scl_now) nfall++;
    if (prev_scl && scl_now && prev_sda && !sda_now) start_cnt++;
    if (prev_scl && scl_now && !prev_sda && sda_now) stop_cnt++;
    prev_scl    = scl_now;
    prev_sda    = sda_now;
    prev_scl_oe = scl_oe;
  end

  // ---------------- checking ----------------
  int vectors = 0, errs = 0;
  int last_sda_t, last_scl_t;
  logic exp_bus = 1'b0, exp_ack = 1'b0;
  logic [7:0] exp_rx = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic nk,
                         output int lat, output bit oe_seen);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    cmd = c; tx_byte = d; nack_on_read = nk; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_id++;
    lat = -1; last_sda_t = -1; last_scl_t = -1; oe_seen = 0;
    for (int t = 1; t <= 5000; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (sda_oe && last_sda_t < 0) last_sda_t = t;
      if (scl_oe && last_scl_t < 0) last_scl_t = t;
      if (sda_oe || scl_oe) oe_seen = 1;
      if (rsp_valid) begin
        lat = t;
        break;
      end
    end
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [7:0] d, input logic nk,
                        input bit sack, input logic [7:0] sbyte, input bit str);
    int lat, s0, p0, exp_lat;
    bit oe, legal;
    slv_mode = (c == 2'b10) ? 1 : (c == 2'b11) ? 2 : 0;
    slv_ack = sack; slv_byte = sbyte; stretch_arm = str;
    s0 = start_cnt; p0 = stop_cnt;
    legal = (c == 2'b00) || exp_bus;
    run_cmd(c, d, nk, lat, oe);
    stretch_arm = 0;
    slv_mode = 0;
    if (!legal) begin
      exp_lat = 1;
      exp_ack = 1'b1;
      chk("illegal_no_bus_activity", 32'(oe), 0);
    end else begin
      case (c)
        2'b00: begin
          exp_lat = QLAT; exp_bus = 1'b1;
          chk("start_condition_seen", start_cnt - s0, 1);
        end
        2'b01: begin
          exp_lat = QLAT; exp_bus = 1'b0;
          chk("stop_condition_seen", stop_cnt - p0, 1);
          chk("stop_lines_released", {scl_oe, sda_oe}, 0);
        end
        2'b10: begin
          exp_lat = BLAT + (str ? STRETCH : 0);
          exp_ack = ~sack;
          chk("write_bus_bits_n", seen_n, 9);
          chk("write_bus_bits", seen_bits, {d, ~sack});
        end
        default: begin
          exp_lat = BLAT; exp_rx = sbyte;
          chk("read_bus_bits_n", seen_n, 9);
          chk("read_bus_bits", seen_bits, {sbyte, nk});
        end
      endcase
    end
    chk("latency", lat, exp_lat);
    chk("ack_received", ack_received, exp_ack);
    chk("rx_byte", rx_byte, exp_rx);
    chk("bus_active", bus_active, exp_bus);
    chk("busy_at_rsp", busy, 0);
  endtask

  initial begin
    int lat_dummy;
    bit any;
    reset = 1'b0; cmd_valid = 1'b0; cmd = 2'b00; tx_byte = 8'h00; nack_on_read = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rx_byte", rx_byte, 0);
    chk("rst_ack", ack_received, 0);
    chk("rst_bus_active", bus_active, 0);
    @(negedge clk);
    reset = 1'b1;

    // illegal commands with no bus owned
    do_cmd(2'b10, 8'h3C, 1'b0, 1, 8'h00, 0);
    do_cmd(2'b01, 8'h00, 1'b0, 0, 8'h00, 0);

    // START from idle: quarter timing
    do_cmd(2'b00, 8'h00, 1'b0, 0, 8'h00, 0);
    chk("start_sda_fall_cycle", last_sda_t, 2 * CLK_DIV);
    chk("start_scl_fall_cycle", last_scl_t, 3 * CLK_DIV);

    do_cmd(2'b10, 8'hA6, 1'b0, 1, 8'h00, 0);   // address byte, slave ACKs
    do_cmd(2'b11, 8'h00, 1'b1, 0, 8'h5A, 0);   // read 0x5A, NACK
    do_cmd(2'b01, 8'h00, 1'b0, 0, 8'h00, 0);

    // stretched write
    do_cmd(2'b00, 8'h00, 1'b0, 0, 8'h00, 0);
    do_cmd(2'b10, 8'($urandom), 1'b0, 1, 8'h00, 1);

    // randomized command stream
    for (int i = 0; i < 14; i++) begin
      logic [1:0] c;
      c = 2'($urandom_range(0, 3));
      do_cmd(c, 8'($urandom), 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             8'($urandom), (c == 2'b10) && ($urandom_range(0, 2) == 0));
    end
    if (exp_bus) do_cmd(2'b01, 8'h00, 1'b0, 0, 8'h00, 0);

    // reset in the middle of a READ
    do_cmd(2'b00, 8'h00, 1'b0, 0, 8'h00, 0);
    slv_mode = 2; slv_byte = 8'hC3;
    @(negedge clk);
    cmd = 2'b11; nack_on_read = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_id++;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("midread_scl_driven", scl_oe, 1);
    reset = 1'b0;
    #1;
    chk("midrst_lines", {scl_oe, sda_oe}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_bus_active", bus_active, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    slv_mode = 0;
    @(negedge clk);
    reset = 1'b1;
    exp_bus = 1'b0; exp_ack = 1'b0; exp_rx = 8'h00;
    any = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rsp_valid || scl_oe || sda_oe) any = 1;
    end
    chk("midrst_quiet_after", 32'(any), 0);
    lat_dummy = 0;
    do_cmd(2'b11, 8'h00, 1'b0, 0, 8'h77, 0);    // illegal again after reset

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
